// File: rtl/mem_access_arbiter.sv
// Two-port (fetch/data) arbiter onto a byte-wide memory; words are
// split into little-endian byte cycles. Ports: clk/rst_n, if_*, d_*, mem_*, trace_*.
module mem_access_arbiter #(
  parameter int MEM_ADDR_LEN = 16,
  parameter int WORD_SIZE    = 16,
  parameter int MEM_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [MEM_ADDR_LEN-1:0] if_addr,
  output logic                    if_ack,
  output logic [WORD_SIZE-1:0]    if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic                    d_sz,
  input  logic [MEM_ADDR_LEN-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]    d_wdata,
  output logic                    d_ack,
  output logic [WORD_SIZE-1:0]    d_rdata,
  output logic                    err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]    mem_wdata,
  input  logic [MEM_WIDTH-1:0]    mem_rdata,
  output logic                    trace_valid,
  output logic [1:0]              trace_type,
  output logic [MEM_ADDR_LEN-1:0] trace_addr
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    FIN,
    ERR
  } state_t;

  localparam int ZW = WORD_SIZE - MEM_WIDTH;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last_d;
  logic                    r_src_d;
  logic                    r_we;
  logic                    r_byte;
  logic [MEM_ADDR_LEN-1:0] r_addr;
  logic [WORD_SIZE-1:0]    r_wdata;
  logic [MEM_WIDTH-1:0]    r_lo;

  logic                    w_gnt_d;
  logic                    w_gnt;
  logic                    w_take;
  logic                    w_byte;
  logic                    w_odd;
  logic [MEM_ADDR_LEN-1:0] w_addr;
  logic [MEM_ADDR_LEN-1:0] w_addr_p1;
  logic [WORD_SIZE-1:0]    w_rdata;
  logic                    w_ack;

  // Data wins unless it was the last one granted while fetch waits.
  assign w_gnt_d   = d_req & (~if_req | ~r_last_d);
  assign w_gnt     = d_req | if_req;
  assign w_take    = (r_state == IDLE) & w_gnt;
  assign w_addr    = w_gnt_d ? d_addr : if_addr;
  assign w_byte    = w_gnt_d & d_sz;
  assign w_odd     = ~w_byte & w_addr[0];
  assign w_addr_p1 = r_addr + MEM_ADDR_LEN'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_src_d  <= 1'b0;
      r_we     <= 1'b0;
      r_byte   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_last_d <= w_gnt_d;
        r_src_d  <= w_gnt_d;
        r_we     <= w_gnt_d & d_we;
        r_byte   <= w_byte;
        r_addr   <= w_addr;
        r_wdata  <= w_gnt_d ? d_wdata : '0;
      end
      // Low byte read in LO arrives while in HI.
      if (r_state == HI) begin
        r_lo <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_gnt) begin
          w_next = w_odd ? ERR : LO;
        end
      end
      LO:      w_next = r_byte ? FIN : HI;
      HI:      w_next = FIN;
      FIN:     w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    trace_valid = 1'b0;
    trace_type  = 2'd0;
    trace_addr  = '0;
    err         = 1'b0;
    w_ack       = 1'b0;
    w_rdata     = '0;
    unique case (r_state)
      LO: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata[MEM_WIDTH-1:0];
      end
      HI: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_addr_p1;
        mem_wdata = r_wdata[WORD_SIZE-1:MEM_WIDTH];
      end
      FIN: begin
        w_ack       = 1'b1;
        trace_valid = 1'b1;
        trace_addr  = r_addr;
        if (!r_src_d) begin
          trace_type = 2'd2;
        end else if (r_we) begin
          trace_type = 2'd1;
        end else begin
          trace_type = 2'd0;
        end
        if (!r_we) begin
          w_rdata = r_byte ? {{ZW{1'b0}}, mem_rdata}
                           : {mem_rdata, r_lo};
        end
      end
      ERR: begin
        w_ack = 1'b1;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign if_ack   = w_ack & ~r_src_d;
  assign d_ack    = w_ack & r_src_d;
  assign if_rdata = if_ack ? w_rdata : '0;
  assign d_rdata  = d_ack ? w_rdata : '0;

endmodule
